// File: rtl/game_pkg.sv
// game_pkg: state encodings, BCD width and BCD arithmetic helpers shared by the game FSM.
package game_pkg;
  localparam int BCD_W = 8;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COUNTDOWN = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] GAMEOVER  = 3'd3;

  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    if (v == 8'h99) return v;
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
    if (v == 8'h00) return v;
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [BCD_W-1:0] bin2bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
endpackage

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD counter with load, saturating increment and decrement (load wins).
module bcd_counter_2d
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] cnt_o
);
  logic [BCD_W-1:0] cnt_q, cnt_d;

  always_comb
    cnt_d = load_i ? load_val_i : inc_i ? bcd_inc_sat(cnt_q) : dec_i ? bcd_dec(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/game_fsm.sv
// game_fsm: countdown / play / game-over controller with BCD timer and score.
// Define HIGH_SCORE_EN to keep a best-score register; otherwise high_score_bcd is 0.
module game_fsm
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hit,
  output logic [2:0]       current_state,
  output logic [3:0]       countdown_timer,
  output logic [BCD_W-1:0] game_timer_bcd,
  output logic [BCD_W-1:0] score_bcd,
  output logic [BCD_W-1:0] high_score_bcd
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICKS_PER_SEC - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cd_q, cd_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick, sc_load, sc_inc, gt_load, gt_dec;
  logic [BCD_W-1:0] score, gtime;

  assign tick   = presc_q == TICK_MAX;
  assign sc_inc = (state_q == PLAY) && hit;
  assign gt_dec = (state_q == PLAY) && tick;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    sc_load = 1'b0;
    gt_load = 1'b0;
    case (state_q)
      IDLE, GAMEOVER: if (start) begin
        state_d = COUNTDOWN;
        cd_d    = 4'(COUNTDOWN_SEC);
        sc_load = 1'b1;
      end
      COUNTDOWN: if (tick) begin
        gt_load = cd_q == 4'd1;
        state_d = gt_load ? PLAY : COUNTDOWN;
        cd_d    = cd_q - 4'd1;
      end
      PLAY: if (tick && gtime == 8'h01) state_d = GAMEOVER;
      default: state_d = IDLE;
    endcase
    // the prescaler restarts on every state change so each phase gets whole seconds
    presc_d = (tick || state_d != state_q) ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      presc_q <= presc_d;
    end

  bcd_counter_2d u_score (
    .clk(clk), .rst_n(rst_n), .load_i(sc_load), .load_val_i(8'h00),
    .inc_i(sc_inc), .dec_i(1'b0), .cnt_o(score)
  );

  bcd_counter_2d u_gtime (
    .clk(clk), .rst_n(rst_n), .load_i(gt_load), .load_val_i(bin2bcd(GAME_SEC)),
    .inc_i(1'b0), .dec_i(gt_dec), .cnt_o(gtime)
  );

`ifdef HIGH_SCORE_EN
  logic [BCD_W-1:0] hs_q, final_score;
  // a hit on the last tick still counts, so compare against the score's next value
  assign final_score = sc_inc ? bcd_inc_sat(score) : score;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hs_q <= '0;
    else if (state_q == PLAY && state_d == GAMEOVER && final_score > hs_q) hs_q <= final_score;
  assign high_score_bcd = hs_q;
`else
  assign high_score_bcd = 8'h00;
`endif

  assign current_state   = state_q;
  assign countdown_timer = cd_q;
  assign game_timer_bcd  = gtime;
  assign score_bcd       = score;
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: randomized checks of game_fsm against an integer-second reference model.
module tb_game_fsm;
  localparam int T  = 4;
  localparam int CD = 5;
  localparam int GS = 10;
`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, hit = 1'b0;
  logic [2:0] state;
  logic [3:0] cd;
  logic [7:0] gt, sc, hs;
  logic s_start = 1'b0, s_hit = 1'b0;
  logic [2:0] s_state;
  logic [3:0] s_cd;
  logic [7:0] s_gt, s_sc, s_hs;
  int total = 0, bad = 0;
  int m_state, m_cd, m_gt, m_sc, m_hs, m_cyc;

  always #5 clk = ~clk;

  game_fsm #(.TICKS_PER_SEC(T), .COUNTDOWN_SEC(CD), .GAME_SEC(GS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .current_state(state),
    .countdown_timer(cd), .game_timer_bcd(gt), .score_bcd(sc), .high_score_bcd(hs)
  );

  game_fsm #(.TICKS_PER_SEC(1000), .COUNTDOWN_SEC(1), .GAME_SEC(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .hit(s_hit), .current_state(s_state),
    .countdown_timer(s_cd), .game_timer_bcd(s_gt), .score_bcd(s_sc), .high_score_bcd(s_hs)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_cd <= 0; m_gt <= 0; m_sc <= 0; m_hs <= 0; m_cyc <= 0;
    end else begin : mdl
      int ns, ncd, ngt, nsc, nhs;
      bit tk;
      tk = (m_cyc % T) == T - 1;
      ns = m_state; ncd = m_cd; ngt = m_gt; nsc = m_sc; nhs = m_hs;
      if ((m_state == 0 || m_state == 3) && start) begin
        ns = 1; ncd = CD; nsc = 0;
      end else if (m_state == 1 && tk) begin
        ncd = m_cd - 1;
        if (m_cd == 1) begin ns = 2; ngt = GS; end
      end else if (m_state == 2) begin
        if (hit && nsc < 99) nsc = nsc + 1;
        if (tk) begin
          ngt = ngt - 1;
          if (ngt == 0) begin
            ns = 3;
            if (HS_EN && nsc > nhs) nhs = nsc;
          end
        end
      end
      m_cyc <= (ns != m_state) ? 0 : m_cyc + 1;
      m_state <= ns; m_cd <= ncd; m_gt <= ngt; m_sc <= nsc; m_hs <= nhs;
    end
  end

  task automatic step(input logic s, input logic h);
    start = s; hit = h;
    @(negedge clk);
    start = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, cd, gt, sc, hs} !== 31'd0) begin
      bad++; $display("FAIL reset_async: got st=%0d cd=%0d gt=%h sc=%h hs=%h want all 0", state, cd, gt, sc, hs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, $urandom_range(0, 1) == 1);
      total++;
      if ({state, cd, gt, sc, hs} !== 31'd0 || m_state != 0) begin
        bad++; $display("FAIL idle_%0d: got st=%0d cd=%0d gt=%h sc=%h hs=%h want all 0", i, state, cd, gt, sc, hs);
      end
    end
  endtask

  task automatic test_countdown;
    step(1'b1, 1'b0);
    total++;
    if (state !== 3'd1 || cd !== 4'(CD)) begin
      bad++; $display("FAIL cd_start: got st=%0d cd=%0d want st=1 cd=%0d", state, cd, CD);
    end
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      total++;
      if (k < 20 && (state !== 3'd1 || cd !== 4'(CD - k / T))) begin
        bad++; $display("FAIL cd_step_%0d: got st=%0d cd=%0d want st=1 cd=%0d", k, state, cd, CD - k / T);
      end else if (k == 20 && (state !== 3'd2 || cd !== 4'd0 || gt !== 8'h10)) begin
        bad++; $display("FAIL cd_to_play: got st=%0d cd=%0d gt=%h want st=2 cd=0 gt=10", state, cd, gt);
      end
    end
  endtask

  task automatic test_play_hits;
    int pre = 0;
    bit fin;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      if (i >= 9) begin
        total++;
        if (sc !== (i == 9 ? 8'h09 : 8'h10)) begin
          bad++; $display("FAIL hit_carry_%0d: got sc=%h want %0d", i, sc, i);
        end
      end
    end
    for (int i = 0; i < 100 && m_state == 2; i++) begin
      fin = (m_gt == 1) && (m_cyc % T == T - 1);
      if (fin) pre = m_sc;
      step(1'b0, fin ? 1'b1 : 1'($urandom_range(0, 1)));
      total++;
      if (sc !== to_bcd(m_sc) || gt !== to_bcd(m_gt) || state !== 3'(m_state)) begin
        bad++; $display("FAIL play_rand_%0d: got st=%0d gt=%h sc=%h want st=%0d gt=%h sc=%h",
                        i, state, gt, sc, m_state, to_bcd(m_gt), to_bcd(m_sc));
      end
    end
    total++;
    if (state !== 3'd3 || gt !== 8'h00 || sc !== to_bcd(pre + 1)) begin
      bad++; $display("FAIL final_hit: got st=%0d gt=%h sc=%h want st=3 gt=00 sc=%h", state, gt, sc, to_bcd(pre + 1));
    end
    repeat (5) step(1'b0, 1'b1);
    total++;
    if (state !== 3'd3 || sc !== to_bcd(pre + 1)) begin
      bad++; $display("FAIL over_hits: got st=%0d sc=%h want st=3 sc=%h", state, sc, to_bcd(pre + 1));
    end
  endtask

  task automatic test_ignore_and_midreset;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    total++;
    if (state !== 3'd1 || cd !== 4'(CD) || m_cd != CD) begin
      bad++; $display("FAIL start_in_cd: got st=%0d cd=%0d want st=1 cd=%0d", state, cd, CD);
    end
    for (int i = 0; i < 100 && m_state != 2; i++) step(1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    total++;
    if (state !== 3'd2 || sc !== 8'h07) begin
      bad++; $display("FAIL start_in_play: got st=%0d sc=%h want st=2 sc=07", state, sc);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({state, cd, gt, sc, hs} !== 31'd0) begin
      bad++; $display("FAIL midplay_reset: got st=%0d cd=%0d gt=%h sc=%h hs=%h want all 0", state, cd, gt, sc, hs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_high_score;
    int want[2] = '{12, 7};
    for (int g = 0; g < 2; g++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 100 && m_state != 2; i++) step(1'b0, 1'b0);
      repeat (want[g]) step(1'b0, 1'b1);
      for (int i = 0; i < 100 && m_state != 3; i++) step(1'b0, 1'b0);
      total++;
      if (state !== 3'd3 || sc !== to_bcd(want[g]) || hs !== (HS_EN ? 8'h12 : 8'h00) || hs !== to_bcd(m_hs)) begin
        bad++; $display("FAIL high_score_g%0d: got st=%0d sc=%h hs=%h want st=3 sc=%h hs=%h",
                        g, state, sc, hs, to_bcd(want[g]), HS_EN ? 8'h12 : 8'h00);
      end
    end
  endtask

  task automatic test_saturation;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 1100 && s_state != 3'd2; i++) @(negedge clk);
    total++;
    if (s_state !== 3'd2) begin
      bad++; $display("FAIL sat_reach_play: got st=%0d want 2", s_state);
    end
    for (int n = 1; n <= 105; n++) begin
      s_hit = 1'b1;
      @(negedge clk);
      s_hit = 1'b0;
      if (n == 9 || n == 10 || n == 98 || n == 99 || n == 100 || n == 105) begin
        total++;
        if (s_sc !== to_bcd(n > 99 ? 99 : n)) begin
          bad++; $display("FAIL sat_%0d: got sc=%h want %h", n, s_sc, to_bcd(n > 99 ? 99 : n));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_countdown;
    test_play_hits;
    test_ignore_and_midreset;
    test_high_score;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
